qosc_minsky_gen: RTL and testbench
==================================

Name: qosc_minsky_gen

Overview:
Parametrised digital quadrature oscillator and successor to the fixed qosc core. It uses the Minsky coupled-form recurrence to generate signed cosine and sine samples of WIDTH bits. Features: runtime frequency shift, prescaler, amplitude, restart, saturation, square-wave quadrature outputs and a per-period pulse. It sits behind the tt_um top wrapper; cfg writes come from ui_in/uio_in decode, and outputs go to uo_out/uio_out muxing.

Parameters:
WIDTH, 12, sample width in bits, signed two's complement; legal range 9..16.
DIV_W, 8, prescaler register width.
SHIFT_MIN, 2, smallest legal frequency shift k.
SHIFT_MAX, 9, largest legal frequency shift k; must be < WIDTH-1.
SHIFT_RST, 6, reset value of k.
AMP_RST, 8'hC0, reset value of the amplitude register.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
ena  in  1  block enable; low freezes all state (no steps, cfg writes ignored).
cfg_we  in  1  config write strobe, one clk per write.
cfg_addr  in  2  0=ctrl, 1=shift, 2=div, 3=amp.
cfg_data  in  8  write data.
cos_o  out  WIDTH  signed x sample.
sin_o  out  WIDTH  signed y sample.
step_o  out  1  one-clk pulse in the cycle cos_o/sin_o take a new value.
sq_i_o  out  1  ~cos_o[WIDTH-1].
sq_q_o  out  1  ~sin_o[WIDTH-1].
wrap_o  out  1  one-clk pulse on each sin_o negative-to-nonnegative transition.
run_o  out  1  current run bit.

Behaviour:
- Reset (async assert, sync release):
  - run=0, k=SHIFT_RST, div=0, amp=AMP_RST, prescaler count=0.
  - x={1'b0,AMP_RST,(WIDTH-9)'b0}, y=0.
  - step_o=0, wrap_o=0.
  - sq_i_o=1, sq_q_o=1.
- Config writes (only when ena=1 and cfg_we=1; take effect on the next edge):
  - addr0: bit0 sets run; bit1 is a restart strobe (not stored); bits 7:2 ignored.
  - addr1: k is cfg_data[3:0] clamped to [SHIFT_MIN,SHIFT_MAX].
  - addr2: div=cfg_data (zero-extended or truncated to DIV_W).
  - addr3: amp=cfg_data; x/y are not affected until restart.
- Restart: x={0,amp,0...}, y=0, prescaler=0, no step_o and no wrap_o that cycle. It uses the amp value held before the write edge. If restart and run=1 are written together, both apply and the first step occurs div+1 cycles later.
- Prescaler: counts 0..div only while run=1 and ena=1; a step fires on the edge where count==div, then count returns to 0. div=0 steps every cycle. Writing div mid-count takes effect immediately; if count>div, count wraps to 0 on the next enabled edge without a step. run=0 holds the count.
- Step (sequential Minsky, arithmetic right shifts, full internal precision WIDTH+1):
  - x' = sat(x - (y>>>k))
  - y' = sat(y + (x'>>>k))
  - sat clips to [-(2^(WIDTH-1)-1), 2^(WIDTH-1)-1]; -2^(WIDTH-1) is never produced.
  - Registered; latency is one clk from step decision to visible samples. step_o is high in that same visible cycle.
- wrap_o: asserted in a step cycle where the previous sin_o[MSB]=1 and the new one is 0.
- ena low mid-operation freezes everything including outputs; pulses drop to 0. Resuming continues from the exact state.
- Reset mid-step discards the step.

Decomposition:
- Package qosc_pkg:
  - cfg address localparams (CFG_CTRL=0, CFG_SHIFT=1, CFG_DIV=2, CFG_AMP=3).
  - ctrl bit indices.
  - shift width constant (4).
  - saturating add function sat_add(a,b,WIDTH).
- Sub-module qosc_prescaler (DIV_W): a run/div counter emitting a step strobe, with sync clear on restart.

Test Plan:
1. Reset, read outputs → cos_o=1536, sin_o=0, step_o=0, run_o=0, sq_i_o=1, sq_q_o=1 (WIDTH=12).
2. Write amp=0x80, k=2, div=0, ctrl=0x03 → cos/sin successive values: (1024,256), (960,496), (836,705); step_o high every cycle.
3. k=6, div=0, run → successive wrap_o pulses spaced 402 or 403 steps apart; |cos_o| peak within 1536±16.
4. div=3, run → step_o exactly every 4th clk. Write div=0 mid-count at count=2 → next enabled clk produces no step, then steps every clk.
5. amp=0xFF, k=2 → sin_o/cos_o reach 2047 or -2047 and never exceed ±2047; no sign flip glitch at the peaks.
6. Write k=15 → k clamps to 9. Drop ena for 10 clks mid-run → outputs and count frozen, cfg write ignored. Assert rst_n low mid-run → immediate reset values without a clock edge.

Source files
------------

// File: rtl/qosc_pkg.sv
// qosc_pkg: shared config addresses, ctrl bit indices and the saturating adder
// for the Minsky quadrature oscillator.
package qosc_pkg;
  localparam logic [1:0] CFG_CTRL  = 2'd0;
  localparam logic [1:0] CFG_SHIFT = 2'd1;
  localparam logic [1:0] CFG_DIV   = 2'd2;
  localparam logic [1:0] CFG_AMP   = 2'd3;
  localparam int CTRL_RUN     = 0;
  localparam int CTRL_RESTART = 1;
  localparam int SHIFT_W      = 4;
  // Operands are sign-extended w-bit samples; the result clips to the
  // symmetric range +/-(2^(w-1)-1) so the most negative code never appears.
  function automatic logic signed [16:0] sat_add(input logic signed [16:0] a,
                                                 input logic signed [16:0] b,
                                                 input int w);
    logic signed [17:0] s, lim, r;
    s = {a[16], a} + {b[16], b};
    lim = (18'sd1 <<< (w - 1)) - 18'sd1;
    r = s > lim ? lim : (s < -lim ? -lim : s);
    return r[16:0];
  endfunction
endpackage

// File: rtl/qosc_minsky_gen_if.sv
// qosc_minsky_gen_if: config write bus (we strobe, 2-bit addr, 8-bit data).
// master drives the bus, slave (the oscillator) samples it.
interface qosc_minsky_gen_if;
  logic       we;
  logic [1:0] addr;
  logic [7:0] data;
  modport master(output we, addr, data);
  modport slave(input we, addr, data);
endinterface

// File: rtl/qosc_prescaler.sv
// qosc_prescaler: counts 0..div while en, fire on count==div.
// Ports: clk, rst_n (async low), en (run & ena), clr (sync restart), div, fire.
module qosc_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             fire
);
  logic [DIV_W-1:0] cnt;
  assign fire = en && !clr && cnt == div;
  // A count left above a freshly lowered div wraps to zero without firing.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt >= div ? '0 : cnt + 1'b1;
endmodule

// File: rtl/qosc_minsky_gen.sv
// qosc_minsky_gen: Minsky coupled-form quadrature oscillator.
// Ports: clk, rst_n (async low), ena (freeze when low), cfg (config bus),
// cos_o/sin_o samples, step_o new-sample pulse, sq_i_o/sq_q_o square waves,
// wrap_o per-period pulse, run_o run bit.
module qosc_minsky_gen
  import qosc_pkg::*;
#(
  parameter int         WIDTH     = 12,
  parameter int         DIV_W     = 8,
  parameter int         SHIFT_MIN = 2,
  parameter int         SHIFT_MAX = 9,
  parameter int         SHIFT_RST = 6,
  parameter logic [7:0] AMP_RST   = 8'hC0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  qosc_minsky_gen_if.slave        cfg,
  output logic signed [WIDTH-1:0] cos_o,
  output logic signed [WIDTH-1:0] sin_o,
  output logic                    step_o,
  output logic                    sq_i_o,
  output logic                    sq_q_o,
  output logic                    wrap_o,
  output logic                    run_o
);
  function automatic logic signed [WIDTH-1:0] amp_x(input logic [7:0] a);
    return WIDTH'({1'b0, a}) << (WIDTH - 9);
  endfunction
  logic signed [WIDTH-1:0] x, y;
  logic [SHIFT_W-1:0]      k, kd, k_new;
  logic [DIV_W-1:0]        div;
  logic [7:0]              amp;
  logic                    run, wr, restart, fire;
  logic signed [16:0]      xn, yn;
  assign wr      = ena && cfg.we;
  assign restart = wr && cfg.addr == CFG_CTRL && cfg.data[CTRL_RESTART];
  assign kd      = cfg.data[SHIFT_W-1:0];
  assign k_new   = kd < SHIFT_MIN ? SHIFT_W'(SHIFT_MIN) : kd > SHIFT_MAX ? SHIFT_W'(SHIFT_MAX) : kd;
  // Sequential form: y update uses the already-updated x, which keeps the orbit closed.
  always_comb begin
    xn = sat_add(17'(x), -17'(y >>> k), WIDTH);
    yn = sat_add(17'(y), xn >>> k, WIDTH);
  end
  qosc_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ena && run),
    .clr  (restart),
    .div  (div),
    .fire (fire)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run    <= 1'b0;
      k      <= SHIFT_W'(SHIFT_RST);
      div    <= '0;
      amp    <= AMP_RST;
      x      <= amp_x(AMP_RST);
      y      <= '0;
      step_o <= 1'b0;
      wrap_o <= 1'b0;
    end else if (ena) begin
      if (wr && cfg.addr == CFG_CTRL) run <= cfg.data[CTRL_RUN];
      if (wr && cfg.addr == CFG_SHIFT) k <= k_new;
      if (wr && cfg.addr == CFG_DIV) div <= DIV_W'(cfg.data);
      if (wr && cfg.addr == CFG_AMP) amp <= cfg.data;
      step_o <= fire;
      wrap_o <= fire && y[WIDTH-1] && !yn[WIDTH-1];
      if (restart) begin
        x <= amp_x(amp);
        y <= '0;
      end else if (fire) begin
        x <= xn[WIDTH-1:0];
        y <= yn[WIDTH-1:0];
      end
    end else begin
      step_o <= 1'b0;
      wrap_o <= 1'b0;
    end
  assign cos_o  = x;
  assign sin_o  = y;
  assign sq_i_o = ~x[WIDTH-1];
  assign sq_q_o = ~y[WIDTH-1];
  assign run_o  = run;
endmodule

// File: tb/tb_qosc_minsky_gen.sv
// tb_qosc_minsky_gen: directed self-checking bench for qosc_minsky_gen (WIDTH=12).
module tb_qosc_minsky_gen;
  import qosc_pkg::*;
  logic clk = 0, rst_n = 1, ena = 1;
  logic signed [11:0] cos_o, sin_o;
  logic step_o, sq_i_o, sq_q_o, wrap_o, run_o;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  qosc_minsky_gen_if cfg();
  qosc_minsky_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .cfg   (cfg),
    .cos_o (cos_o),
    .sin_o (sin_o),
    .step_o(step_o),
    .sq_i_o(sq_i_o),
    .sq_q_o(sq_q_o),
    .wrap_o(wrap_o),
    .run_o (run_o)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg.we = 1; cfg.addr = a; cfg.data = d;
    @(negedge clk);
    cfg.we = 0;
  endtask
  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction
  initial begin
    int last, nw, pk, pks, oob, glitch, frz, c0, s0, pc, ps;
    int sp[2];
    cfg.we = 0; cfg.addr = 0; cfg.data = 0;
    #1 rst_n = 0;
    #1;
    check("rst_async_cos", cos_o, 1536);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_cos", cos_o, 1536);
    check("rst_sin", sin_o, 0);
    check("rst_step", step_o, 0);
    check("rst_run", run_o, 0);
    check("rst_sqi", sq_i_o, 1);
    check("rst_sqq", sq_q_o, 1);
    check("rst_wrap", wrap_o, 0);
    // k=6 free run: wrap spacing and peak amplitude
    wr(CFG_CTRL, 8'h03);
    last = 0; nw = 0; pk = 0; sp[0] = 0; sp[1] = 0;
    for (int i = 0; i < 2000 && nw < 3; i++) begin
      @(negedge clk);
      if (iabs(cos_o) > pk) pk = iabs(cos_o);
      if (wrap_o) begin
        if (nw > 0) sp[nw-1] = i - last;
        last = i;
        nw++;
      end
    end
    check("t3_wraps", nw, 3);
    check($sformatf("t3_sp0=%0d_in_402_403", sp[0]), int'(sp[0] == 402 || sp[0] == 403), 1);
    check($sformatf("t3_sp1=%0d_in_402_403", sp[1]), int'(sp[1] == 402 || sp[1] == 403), 1);
    check($sformatf("t3_peak=%0d_in_1520_1552", pk), int'(pk >= 1520 && pk <= 1552), 1);
    // k=2 sequence from amp 0x80
    wr(CFG_AMP, 8'h80);
    wr(CFG_SHIFT, 8'h02);
    wr(CFG_DIV, 8'h00);
    wr(CFG_CTRL, 8'h03);
    check("t2_restart_cos", cos_o, 1024);
    check("t2_restart_sin", sin_o, 0);
    check("t2_restart_step", step_o, 0);
    @(negedge clk);
    check("t2_cos1", cos_o, 1024); check("t2_sin1", sin_o, 256); check("t2_step1", step_o, 1);
    @(negedge clk);
    check("t2_cos2", cos_o, 960); check("t2_sin2", sin_o, 496); check("t2_step2", step_o, 1);
    @(negedge clk);
    check("t2_cos3", cos_o, 836); check("t2_sin3", sin_o, 705); check("t2_step3", step_o, 1);
    check("t2_sqq", sq_q_o, 1);
    // saturation at amp 0xFF, k=2
    wr(CFG_AMP, 8'hFF);
    wr(CFG_CTRL, 8'h03);
    pks = 0; oob = 0; glitch = 0; pc = cos_o; ps = sin_o;
    repeat (300) begin
      @(negedge clk);
      if (iabs(sin_o) > pks) pks = iabs(sin_o);
      if (iabs(sin_o) > 2047 || iabs(cos_o) > 2047) oob++;
      if (iabs(sin_o - ps) > 600 || iabs(cos_o - pc) > 600) glitch++;
      pc = cos_o; ps = sin_o;
    end
    check("t5_peak_sin", pks, 2047);
    check("t5_out_of_range", oob, 0);
    check("t5_glitches", glitch, 0);
    // prescaler div=3, then div=0 mid-count
    wr(CFG_AMP, 8'h80);
    wr(CFG_DIV, 8'h03);
    wr(CFG_CTRL, 8'h03);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      check($sformatf("t4_step%0d", i), step_o, int'(i % 4 == 0));
    end
    wr(CFG_DIV, 8'h00);
    check("t4_wr_edge", step_o, 0);
    @(negedge clk);
    check("t4_wrap_edge", step_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t4_fast%0d", i), step_o, 1);
    end
    // shift clamping
    wr(CFG_SHIFT, 8'h0F);
    wr(CFG_CTRL, 8'h03);
    @(negedge clk);
    check("t6_k15_cos", cos_o, 1024);
    check("t6_k15_sin", sin_o, 2);
    wr(CFG_SHIFT, 8'h00);
    wr(CFG_CTRL, 8'h03);
    @(negedge clk);
    check("t6_k0_sin", sin_o, 256);
    // ena freeze with div=1, k=4
    wr(CFG_SHIFT, 8'h04);
    wr(CFG_DIV, 8'h01);
    wr(CFG_CTRL, 8'h03);
    @(negedge clk); check("t6_p1", step_o, 0);
    @(negedge clk); check("t6_p2", step_o, 1);
    @(negedge clk); check("t6_p3", step_o, 0);
    c0 = cos_o; s0 = sin_o;
    check("t6_pre_cos", c0, 1024);
    check("t6_pre_sin", s0, 64);
    ena = 0; cfg.we = 1; cfg.addr = CFG_CTRL; cfg.data = 8'h00;
    frz = 0;
    repeat (10) begin
      @(negedge clk);
      if (cos_o != c0 || sin_o != s0 || step_o || wrap_o) frz++;
    end
    check("t6_frozen", frz, 0);
    ena = 1; cfg.we = 0;
    @(negedge clk);
    check("t6_resume_step", step_o, 1);
    check("t6_resume_cos", cos_o, 1020);
    check("t6_resume_sin", sin_o, 127);
    check("t6_run_kept", run_o, 1);
    // async reset between edges
    #1 rst_n = 0;
    #1;
    check("t6_areset_cos", cos_o, 1536);
    check("t6_areset_sin", sin_o, 0);
    check("t6_areset_run", run_o, 0);
    check("t6_areset_step", step_o, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
